coilgun_core: RTL and testbench
===============================

# coilgun_core

Single-stage coilgun firing controller. It arms on a trigger rising edge, waits an optional programmable delay, then drives the coil-switch output until a time limit expires, an external gate signal arrives or the trigger is released. It then reports end-of-shot and the measured cycle count. It sits between the operator/sensor inputs and the coil driver, with its configuration word supplied by a host register block.

## Interface
Parameters: none (all widths fixed at 24 bits).

- clk  in  1  single system clock; all state updates on rising edge
- I_RST  in  1  synchronous, active-low reset
- I_TRIG  in  1  fire request; a rising edge starts a shot, holding it high sustains the shot
- I_GATE  in  1  external stop sensor; high ends the FIRE phase unless I_LDS=1
- O_EXT  out  1  coil switch drive
- O_SOE  out  1  shot-over event; one-cycle pulse
- I_LMT  in  24  FIRE duration limit, in clk cycles
- I_DLY  in  24  pre-fire delay, in clk cycles
- I_OE  in  1  output enable; gates O_EXT only
- I_EN  in  1  core enable
- I_DDS  in  1  delay disable; 1 = skip DELAY
- I_LDS  in  1  gate-stop disable; 1 = I_GATE ignored
- I_LEN  in  1  limit enable; 1 = FIRE ends after I_LMT cycles
- O_RTE  out  1  ready to engage (armed)
- O_ACC  out  24  phase cycle accumulator

## Operation
- States: IDLE, DELAY, FIRE, DONE. Configuration inputs are read live every cycle, with no shadow registers.
- Trigger edge: trig_prev is a register that resets to 1. A shot therefore requires a fresh 0→1 edge after reset.
- IDLE:
  - Start condition: I_EN=1, I_TRIG=1 and trig_prev=0.
  - On start: ACC←0. Next state is DELAY if I_DDS=0 and I_DLY≠0, otherwise FIRE.
- DELAY:
  - ACC increments each cycle.
  - When ACC = I_DLY−1: next state FIRE, ACC←0.
- FIRE:
  - ACC increments each cycle, saturating at 24'hFFFFFF.
  - Exit to DONE when any of these holds:
    - I_LEN=1 and ACC ≥ max(I_LMT,1)−1
    - I_LDS=0 and I_GATE=1
    - I_TRIG=0
  - On the exit cycle ACC takes its incremented value, so O_ACC in DONE equals the number of FIRE cycles.
- Abort: I_TRIG=0 or I_EN=0 during DELAY or FIRE moves to DONE next cycle.
- DONE: ACC holds. Returns to IDLE when I_TRIG=0.
- Outputs:
  - O_EXT = (state==FIRE) & I_OE & I_EN. It has no combinational path from I_TRIG, I_GATE or I_LMT.
  - O_SOE is a registered pulse, high for exactly the first cycle spent in DONE.
  - O_RTE = (state==IDLE) & I_EN & ~I_TRIG.
  - O_ACC is the ACC register. It holds its last value in IDLE and DONE until the next start.
- With I_LEN=0, I_LDS=1 and I_TRIG held high, FIRE continues indefinitely. This is allowed; the host is responsible for it.
- Simultaneous exit causes all route to DONE identically. Priority matters only for I_EN=0, which forces DONE from any active state.

## Timing
- Reset (I_RST=0 at a clk edge):
  - state=IDLE, ACC=0, trig_prev=1, O_SOE=0, so O_EXT=0.
  - O_RTE = I_EN & ~I_TRIG once reset is released.
- Latency:
  - The edge sampled at clock k puts the core in FIRE (or DELAY) at k+1.
  - O_EXT rises in the same cycle the state enters FIRE.
- Durations:
  - O_EXT is high for exactly I_LMT cycles when the limit is the cause (I_LMT=0 behaves as 1).
  - DELAY lasts exactly I_DLY cycles.
- A gate or trigger-release stop seen at edge k makes O_EXT low from k+1.
- O_SOE is high in the cycle O_EXT first returns low (the first DONE cycle).
- Reset asserted mid-shot returns to IDLE at the next edge. The same shot cannot restart until I_TRIG is released and re-asserted.
- Retrigger: I_TRIG must be low for at least one cycle in DONE/IDLE before the next shot.

## Test plan
- Reset/arming:
  - Stimulus: I_RST low then high with I_TRIG=0, I_EN=1.
  - Response: O_EXT=0, O_SOE=0, O_ACC=0, O_RTE=1.
  - Then raise I_TRIG: O_RTE falls and the shot starts.
- Trigger-released shot:
  - Stimulus: I_DDS=I_LDS=I_LEN=I_EN=I_OE=1, I_LMT=200; I_TRIG high for about 21 cycles, then low.
  - Response: O_EXT high from cycle 1 until the cycle after the release, with no limit stop. O_SOE pulses once. O_ACC equals the FIRE cycle count (<200).
- Time limit:
  - Stimulus: same configuration, I_LMT=5, I_TRIG held high.
  - Response: O_EXT high exactly 5 cycles, O_ACC=5, O_SOE one pulse. No refire until I_TRIG toggles.
- Delay:
  - Stimulus: I_DDS=0, I_DLY=3, I_LMT=4.
  - Response: O_EXT rises 4 cycles after the edge-sample clock and stays high 4 cycles.
- Gate stop:
  - Stimulus: I_LDS=0, I_LEN=0; pulse I_GATE in FIRE cycle 7.
  - Response: O_EXT low next cycle, O_ACC=7.
  - Repeat with I_LDS=1: the gate is ignored.
- Output enable and abort:
  - With I_OE=0 the sequence runs (O_ACC counts, O_SOE pulses) and O_EXT stays 0.
  - Driving I_EN=0 mid-FIRE gives DONE next cycle with O_EXT=0.
  - Asserting reset mid-FIRE gives IDLE with O_ACC=0.

Source files
------------

// File: rtl/coilgun_core.sv
// coilgun_core: single-stage coilgun firing controller.
// Arms on a trigger rising edge, optionally waits a programmed delay, then
// drives the coil switch until the limit, gate sensor or trigger release
// ends the shot, and reports end-of-shot plus the measured cycle count.
//
// state | meaning
// IDLE  | waiting for a fresh trigger edge while enabled
// DELAY | counting the pre-fire delay
// FIRE  | coil switch driven, counting fire cycles
// DONE  | shot over, count held; waits for trigger release
module coilgun_core (
  input  logic        clk,
  input  logic        I_RST,
  input  logic        I_TRIG,
  input  logic        I_GATE,
  output logic        O_EXT,
  output logic        O_SOE,
  input  logic [23:0] I_LMT,
  input  logic [23:0] I_DLY,
  input  logic        I_OE,
  input  logic        I_EN,
  input  logic        I_DDS,
  input  logic        I_LDS,
  input  logic        I_LEN,
  output logic        O_RTE,
  output logic [23:0] O_ACC
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] FIRE  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [23:0] acc, acc_nxt;
  logic        trig_prev;
  logic        soe;

  logic [23:0] lmt_eff;
  logic [23:0] acc_sat_inc;
  logic        fire_exit;

  // A zero limit is treated as one cycle so the compare never underflows.
  assign lmt_eff     = (I_LMT == 24'd0) ? 24'd1 : I_LMT;
  assign acc_sat_inc = (acc == 24'hFFFFFF) ? acc : acc + 24'd1;
  assign fire_exit   = ~I_EN | ~I_TRIG
                     | (I_LEN & (acc >= lmt_eff - 24'd1))
                     | (~I_LDS & I_GATE);

  // Next-state and accumulator update logic.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    case (state)
      IDLE: begin
        if (I_EN && I_TRIG && !trig_prev) begin
          acc_nxt   = 24'd0;
          state_nxt = (!I_DDS && (I_DLY != 24'd0)) ? DELAY : FIRE;
        end
      end
      DELAY: begin
        if (!I_EN || !I_TRIG) begin
          acc_nxt   = acc + 24'd1;
          state_nxt = DONE;
        end else if (acc == I_DLY - 24'd1) begin
          acc_nxt   = 24'd0;
          state_nxt = FIRE;
        end else begin
          acc_nxt   = acc + 24'd1;
        end
      end
      FIRE: begin
        // The exit cycle still counts, so the held value equals FIRE cycles.
        acc_nxt = acc_sat_inc;
        if (fire_exit) state_nxt = DONE;
      end
      DONE: begin
        if (!I_TRIG) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, accumulator, trigger history and shot-over pulse registers.
  always_ff @(posedge clk) begin
    if (!I_RST) begin
      state     <= IDLE;
      acc       <= 24'd0;
      trig_prev <= 1'b1;
      soe       <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      trig_prev <= I_TRIG;
      soe       <= (state_nxt == DONE) && (state != DONE);
    end
  end

  assign O_EXT = (state == FIRE) & I_OE & I_EN;
  assign O_SOE = soe;
  assign O_RTE = (state == IDLE) & I_EN & ~I_TRIG;
  assign O_ACC = acc;

endmodule

// File: tb/tb_coilgun_core.sv
// Directed bench for coilgun_core: reset/arming, trigger release, limit,
// delay, gate stop, output enable, enable abort and mid-shot reset.
module tb_coilgun_core;

  logic        clk = 1'b0;
  logic        I_RST, I_TRIG, I_GATE, I_OE, I_EN, I_DDS, I_LDS, I_LEN;
  logic [23:0] I_LMT, I_DLY;
  logic        O_EXT, O_SOE, O_RTE;
  logic [23:0] O_ACC;

  int tests = 0;
  int fails = 0;

  coilgun_core dut (
    .clk(clk), .I_RST(I_RST), .I_TRIG(I_TRIG), .I_GATE(I_GATE),
    .O_EXT(O_EXT), .O_SOE(O_SOE), .I_LMT(I_LMT), .I_DLY(I_DLY),
    .I_OE(I_OE), .I_EN(I_EN), .I_DDS(I_DDS), .I_LDS(I_LDS),
    .I_LEN(I_LEN), .O_RTE(O_RTE), .O_ACC(O_ACC)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles, counting O_EXT-high cycles, O_SOE pulses and the first
  // cycle (1-based) in which O_EXT was seen high (0 if never).
  task automatic run_cycles(input int n, output int ext_cnt, output int soe_cnt,
                            output int first_ext);
    ext_cnt = 0; soe_cnt = 0; first_ext = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (O_EXT === 1'b1) begin
        ext_cnt++;
        if (first_ext == 0) first_ext = i;
      end
      if (O_SOE === 1'b1) soe_cnt++;
    end
  endtask

  task automatic release_trig();
    I_TRIG = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    I_RST = 1'b0; I_TRIG = 1'b0; I_GATE = 1'b0; I_OE = 1'b1; I_EN = 1'b1;
    I_DDS = 1'b1; I_LDS = 1'b1; I_LEN = 1'b1; I_LMT = 24'd200; I_DLY = 24'd0;
    tick(); tick();
    tests++; if (O_EXT !== 1'b0) begin fails++; $display("FAIL reset_ext got %0b want 0", O_EXT); end
    tests++; if (O_SOE !== 1'b0) begin fails++; $display("FAIL reset_soe got %0b want 0", O_SOE); end
    tests++; if (O_ACC !== 24'd0) begin fails++; $display("FAIL reset_acc got %0d want 0", O_ACC); end
    I_RST = 1'b1;
    tick();
    tests++; if (O_RTE !== 1'b1) begin fails++; $display("FAIL reset_rte got %0b want 1", O_RTE); end
    I_TRIG = 1'b1;
    #1;
    tests++; if (O_RTE !== 1'b0) begin fails++; $display("FAIL arm_rte_fall got %0b want 0", O_RTE); end
    tick();
    tests++; if (O_EXT !== 1'b1) begin fails++; $display("FAIL arm_shot_start got %0b want 1", O_EXT); end
    release_trig();
    // Trigger held high through reset must not fire: trig_prev resets to 1.
    I_RST = 1'b0; I_TRIG = 1'b1;
    tick();
    I_RST = 1'b1;
    tick(); tick(); tick();
    tests++; if (O_EXT !== 1'b0) begin fails++; $display("FAIL reset_no_fire got %0b want 0", O_EXT); end
    release_trig();
  endtask

  task automatic test_trig_release();
    int ext_cnt, soe_cnt, first;
    I_DDS = 1'b1; I_LDS = 1'b1; I_LEN = 1'b1; I_LMT = 24'd200;
    I_TRIG = 1'b1;
    run_cycles(21, ext_cnt, soe_cnt, first);
    tests++; if (ext_cnt != 21) begin fails++; $display("FAIL rel_ext_cnt got %0d want 21", ext_cnt); end
    tests++; if (first != 1) begin fails++; $display("FAIL rel_first_ext got %0d want 1", first); end
    I_TRIG = 1'b0;
    tick();
    tests++; if (O_EXT !== 1'b0) begin fails++; $display("FAIL rel_ext_low got %0b want 0", O_EXT); end
    tests++; if (O_SOE !== 1'b1) begin fails++; $display("FAIL rel_soe got %0b want 1", O_SOE); end
    tests++; if (O_ACC !== 24'd21) begin fails++; $display("FAIL rel_acc got %0d want 21", O_ACC); end
    tick();
    tests++; if (O_SOE !== 1'b0) begin fails++; $display("FAIL rel_soe_once got %0b want 0", O_SOE); end
    tests++; if (O_RTE !== 1'b1) begin fails++; $display("FAIL rel_rte got %0b want 1", O_RTE); end
    tests++; if (O_ACC !== 24'd21) begin fails++; $display("FAIL rel_acc_hold got %0d want 21", O_ACC); end
  endtask

  task automatic test_limit();
    int ext_cnt, soe_cnt, first;
    I_LMT = 24'd5;
    I_TRIG = 1'b1;
    run_cycles(12, ext_cnt, soe_cnt, first);
    tests++; if (ext_cnt != 5) begin fails++; $display("FAIL lmt_ext_cnt got %0d want 5", ext_cnt); end
    tests++; if (soe_cnt != 1) begin fails++; $display("FAIL lmt_soe_cnt got %0d want 1", soe_cnt); end
    tests++; if (O_ACC !== 24'd5) begin fails++; $display("FAIL lmt_acc got %0d want 5", O_ACC); end
    release_trig();
    I_LMT = 24'd0;
    I_TRIG = 1'b1;
    run_cycles(6, ext_cnt, soe_cnt, first);
    tests++; if (ext_cnt != 1) begin fails++; $display("FAIL lmt0_ext_cnt got %0d want 1", ext_cnt); end
    tests++; if (O_ACC !== 24'd1) begin fails++; $display("FAIL lmt0_acc got %0d want 1", O_ACC); end
    release_trig();
  endtask

  task automatic test_delay();
    int ext_cnt, soe_cnt, first;
    I_DDS = 1'b0; I_DLY = 24'd3; I_LMT = 24'd4;
    I_TRIG = 1'b1;
    run_cycles(14, ext_cnt, soe_cnt, first);
    tests++; if (first != 4) begin fails++; $display("FAIL dly_first_ext got %0d want 4", first); end
    tests++; if (ext_cnt != 4) begin fails++; $display("FAIL dly_ext_cnt got %0d want 4", ext_cnt); end
    tests++; if (O_ACC !== 24'd4) begin fails++; $display("FAIL dly_acc got %0d want 4", O_ACC); end
    release_trig();
    I_DLY = 24'd0;
    I_TRIG = 1'b1;
    run_cycles(8, ext_cnt, soe_cnt, first);
    tests++; if (first != 1) begin fails++; $display("FAIL dly0_first_ext got %0d want 1", first); end
    release_trig();
    I_DDS = 1'b1;
  endtask

  task automatic test_gate();
    I_LDS = 1'b0; I_LEN = 1'b0;
    I_TRIG = 1'b1;
    repeat (7) tick();
    tests++; if (O_EXT !== 1'b1) begin fails++; $display("FAIL gate_pre_ext got %0b want 1", O_EXT); end
    I_GATE = 1'b1;
    tick();
    I_GATE = 1'b0;
    tests++; if (O_EXT !== 1'b0) begin fails++; $display("FAIL gate_ext_low got %0b want 0", O_EXT); end
    tests++; if (O_ACC !== 24'd7) begin fails++; $display("FAIL gate_acc got %0d want 7", O_ACC); end
    tests++; if (O_SOE !== 1'b1) begin fails++; $display("FAIL gate_soe got %0b want 1", O_SOE); end
    release_trig();
    I_LDS = 1'b1;
    I_TRIG = 1'b1;
    repeat (7) tick();
    I_GATE = 1'b1;
    tick();
    I_GATE = 1'b0;
    tests++; if (O_EXT !== 1'b1) begin fails++; $display("FAIL gate_ignored got %0b want 1", O_EXT); end
    I_TRIG = 1'b0;
    tick();
    tests++; if (O_ACC !== 24'd8) begin fails++; $display("FAIL gate_ign_acc got %0d want 8", O_ACC); end
    tick();
    I_LEN = 1'b1;
  endtask

  task automatic test_oe_abort();
    int ext_cnt, soe_cnt, first;
    I_OE = 1'b0; I_LMT = 24'd5;
    I_TRIG = 1'b1;
    run_cycles(10, ext_cnt, soe_cnt, first);
    tests++; if (ext_cnt != 0) begin fails++; $display("FAIL oe_ext_cnt got %0d want 0", ext_cnt); end
    tests++; if (soe_cnt != 1) begin fails++; $display("FAIL oe_soe_cnt got %0d want 1", soe_cnt); end
    tests++; if (O_ACC !== 24'd5) begin fails++; $display("FAIL oe_acc got %0d want 5", O_ACC); end
    release_trig();
    I_OE = 1'b1; I_LEN = 1'b0;
    I_TRIG = 1'b1;
    repeat (3) tick();
    I_EN = 1'b0;
    tick();
    tests++; if (O_EXT !== 1'b0) begin fails++; $display("FAIL abort_ext got %0b want 0", O_EXT); end
    tests++; if (O_SOE !== 1'b1) begin fails++; $display("FAIL abort_soe got %0b want 1", O_SOE); end
    tests++; if (O_ACC !== 24'd3) begin fails++; $display("FAIL abort_acc got %0d want 3", O_ACC); end
    I_EN = 1'b1;
    release_trig();
    I_TRIG = 1'b1;
    repeat (3) tick();
    I_RST = 1'b0;
    tick();
    tests++; if (O_ACC !== 24'd0) begin fails++; $display("FAIL rst_mid_acc got %0d want 0", O_ACC); end
    tests++; if (O_EXT !== 1'b0) begin fails++; $display("FAIL rst_mid_ext got %0b want 0", O_EXT); end
    I_RST = 1'b1;
    tick(); tick();
    tests++; if (O_EXT !== 1'b0) begin fails++; $display("FAIL rst_no_restart got %0b want 0", O_EXT); end
    I_TRIG = 1'b0;
    tick();
    tests++; if (O_RTE !== 1'b1) begin fails++; $display("FAIL rst_idle_rte got %0b want 1", O_RTE); end
    I_TRIG = 1'b1;
    tick();
    tests++; if (O_EXT !== 1'b1) begin fails++; $display("FAIL rst_refire got %0b want 1", O_EXT); end
    release_trig();
  endtask

  initial begin
    test_reset();
    test_trig_release();
    test_limit();
    test_delay();
    test_gate();
    test_oe_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
